// File: rtl/srf04_pkg.sv
// rtl/srf04_pkg.sv - shared SRF04 state encoding, widths and default timing
package srf04_pkg;

  localparam int DIST_W       = 16;
  localparam int TRIG_W_DEF   = 10;
  localparam int MEAS_WIN_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  // Zero or over-range requests fall back to the "no target" width.
  function automatic logic [DIST_W-1:0] clamp_len(input logic [DIST_W-1:0] req,
                                                  input logic [DIST_W-1:0] max_len);
    if (req == '0 || req > max_len) return max_len;
    return req;
  endfunction

endpackage

// File: rtl/srf04_echo_emulator.sv
// rtl/srf04_echo_emulator.sv - SRF04 sensor-side responder: trigger in, delayed echo pulse out
module srf04_echo_emulator
  import srf04_pkg::*;
#(
  parameter int MIN_TRIG  = TRIG_W_DEF,
  parameter int BURST_DLY = 8,
  parameter int ECHO_MAX  = 900,
  parameter int HOLDOFF   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Trigger,
  input  logic [DIST_W-1:0] echo_len,
  output logic              EchoPulse,
  output logic              busy,
  output logic              runt_err,
  output logic              clamped,
  output logic              ign_trig
);

  localparam logic [DIST_W-1:0] MIN_C   = DIST_W'(MIN_TRIG);
  localparam logic [DIST_W-1:0] BURST_C = DIST_W'(BURST_DLY);
  localparam logic [DIST_W-1:0] MAX_C   = DIST_W'(ECHO_MAX);
  localparam logic [DIST_W-1:0] HOLD_C  = DIST_W'(HOLDOFF);
  localparam logic              HAS_HOLD = (HOLDOFF != 0);

  state_t            state;
  logic [DIST_W-1:0] cnt;
  logic [DIST_W-1:0] trig_cnt;
  logic [DIST_W-1:0] len;
  logic              trig_prev;
  logic              trig_rise;

  assign trig_rise = Trigger && !trig_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      trig_cnt  <= '0;
      len       <= '0;
      trig_prev <= 1'b0;
      EchoPulse <= 1'b0;
      busy      <= 1'b0;
      runt_err  <= 1'b0;
      clamped   <= 1'b0;
      ign_trig  <= 1'b0;
    end else begin
      trig_prev <= Trigger;
      runt_err  <= 1'b0;
      clamped   <= 1'b0;
      ign_trig  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig_rise) begin
            state    <= ST_TRIG;
            trig_cnt <= 16'd1;
            busy     <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (Trigger) begin
            if (trig_cnt < MIN_C) trig_cnt <= trig_cnt + 16'd1;
          end else if (trig_cnt >= MIN_C) begin
            len     <= clamp_len(echo_len, MAX_C);
            clamped <= (echo_len == '0) || (echo_len > MAX_C);
            cnt     <= BURST_C;
            state   <= ST_BURST;
          end else begin
            runt_err <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_BURST: begin
          ign_trig <= trig_rise;
          if (cnt == 16'd1) begin
            EchoPulse <= 1'b1;
            cnt       <= len;
            state     <= ST_ECHO;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_ECHO: begin
          ign_trig <= trig_rise;
          if (cnt == 16'd1) begin
            EchoPulse <= 1'b0;
            if (HAS_HOLD) begin
              cnt   <= HOLD_C;
              state <= ST_HOLDOFF;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_HOLDOFF: begin
          ign_trig <= trig_rise;
          if (cnt == 16'd1) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          EchoPulse <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/srf04_echo_emulator.md
Name: srf04_echo_emulator

Overview:
Sensor-side model of the SRF04 ultrasonic ranger; the responder to the SRF04 reader block. Accepts the reader's Trigger pulse, waits a fixed acoustic-burst delay, then drives EchoPulse high for a programmed number of clock cycles representing target distance. Used for on-chip loopback, board bring-up without a sensor, and as the bench partner for the reader.

Parameters:
MIN_TRIG, 10, minimum Trigger high time (cycles) accepted as a valid trigger
BURST_DLY, 8, cycles from accepted Trigger fall to EchoPulse rise (must be >= 1)
ECHO_MAX, 900, maximum echo width (cycles); also the "no target" width
HOLDOFF, 32, cycles after echo fall during which Trigger is ignored

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
Trigger  in  1  trigger from reader, synchronous to clk
echo_len  in  16  desired echo width in cycles; sampled once per measurement
EchoPulse  out  1  emulated echo output, registered
busy  out  1  high in any state other than IDLE
runt_err  out  1  one-cycle pulse: Trigger high fewer than MIN_TRIG cycles
clamped  out  1  one-cycle pulse: latched echo_len was 0 or > ECHO_MAX
ign_trig  out  1  one-cycle pulse: Trigger rising edge seen in BURST/ECHO/HOLDOFF

Behaviour:
- Reset (async assert, clock-synchronous release): state IDLE, all counters 0, EchoPulse/busy/runt_err/clamped/ign_trig = 0. Reset mid-ECHO drops EchoPulse immediately, without a clock edge.
- Single 16-bit down-counter shared by all timed states; 1-bit Trigger history register for edge detection.
- IDLE: rising edge on Trigger (prev 0, now 1) -> TRIG, trig_cnt = 1. A Trigger already high on entry to IDLE is not a trigger; a fresh 0->1 edge is required.
- TRIG: Trigger=1 -> trig_cnt increments, saturating at MIN_TRIG. Trigger=0 at edge E:
  - trig_cnt >= MIN_TRIG: latch len = echo_len, or ECHO_MAX if echo_len==0 or echo_len>ECHO_MAX (pulse clamped in the cycle after E); -> BURST.
  - else: pulse runt_err in the cycle after E; -> IDLE; no echo.
- BURST: EchoPulse=0 for BURST_DLY cycles; EchoPulse first high in the cycle following edge E+BURST_DLY.
- ECHO: EchoPulse=1 for exactly len cycles, falling after edge E+BURST_DLY+len; -> HOLDOFF.
- HOLDOFF: EchoPulse=0 for HOLDOFF cycles; -> IDLE. HOLDOFF=0 returns to IDLE directly after ECHO.
- Trigger rising edge in BURST/ECHO/HOLDOFF: ignored, ign_trig pulses, measurement continues unchanged.
- echo_len changes after the latch do not affect the echo in progress.
- Widths: len is 16-bit; ECHO_MAX must fit 16 bits; no counter wrap is possible.
- busy = (state != IDLE) registered, so it rises with entry to TRIG.

Decomposition:
- Shared package srf04_pkg: state encoding (IDLE, TRIG, BURST, ECHO, HOLDOFF), 16-bit distance width constant, default timing constants shared with the reader (trigger width 10, measurement window 1000).
- No sub-module; one FSM plus the shared down-counter.

Test Plan:
- Trigger high 10 cycles, echo_len=100 -> EchoPulse rises 8 cycles after Trigger fall, high exactly 100 cycles, busy drops 32 cycles after echo fall; paired with the reader, reader D = 100.
- Trigger high 5 cycles -> runt_err one-cycle pulse, EchoPulse stays 0, state back in IDLE the cycle after the fall.
- echo_len=0, then echo_len=5000 -> each gives a 900-cycle echo and a clamped pulse; echo_len=900 gives 900 cycles and no clamped pulse.
- Second 10-cycle Trigger during ECHO, then Trigger held high across the end of HOLDOFF -> ign_trig pulses, only one echo, no new measurement until Trigger goes 0 then 1.
- echo_len changed from 100 to 300 during BURST -> current echo 100 cycles; next measurement 300 cycles.
- rst asserted between clock edges mid-ECHO -> EchoPulse and busy 0 immediately; after release, a valid trigger produces a normal echo.
